timer_irq_unit: RTL and testbench
=================================

TIMER_IRQ_UNIT -- requirements
Module: timer_irq_unit

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, byte address of register block.
REQ-002 Parameter PRESCALE_W, default 8, width of prescaler field and counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 cs  input  1  bus select, qualifies access in current cycle.
REQ-006 wr  input  1  1 = write, 0 = read; valid only with cs.
REQ-007 addr  input  32  byte address; decoded as addr[4:2] relative to BASE_ADDR.
REQ-008 wdata  input  32  write data, byte lanes aligned to mask.
REQ-009 mask  input  4  byte-lane write enables; bit i enables wdata[8i+7:8i].
REQ-010 rdata  output  32  read data, valid while rvalid = 1.
REQ-011 rvalid  output  1  one-cycle read-response strobe.
REQ-012 intrrupt  output  1  level interrupt to core; registered output.

Function
REQ-013 Register map (offset): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI, 0x10 CTRL, 0x14 STATUS.
REQ-014 CTRL: bit0 EN, bit1 AUTO_RELOAD, bits[8+PRESCALE_W-1:8] PRESCALE; other bits read 0.
REQ-015 STATUS: bit0 PEND, write-1-to-clear; other bits read 0, writes ignored.
REQ-016 Access hits only when cs = 1 and addr[31:5] = BASE_ADDR[31:5]; other accesses ignored, no rvalid.
REQ-017 Writes: byte-masked, take effect at the clock edge of the access cycle.
REQ-018 Reads: rdata/rvalid registered, valid exactly 1 cycle after access; unmapped offsets 0x18-0x1C return 0 with rvalid = 1.
REQ-019 Prescaler counter: while EN = 1, increments each cycle; at value = PRESCALE it clears to 0 and issues one tick; PRESCALE = 0 ticks every cycle.
REQ-020 On tick, 64-bit MTIME increments by 1, wraps from 2^64-1 to 0.
REQ-021 EN = 0: prescaler and MTIME hold; writing EN 0->1 clears prescaler counter to 0.
REQ-022 Match: EN = 1 and MTIME >= {CMP_HI, CMP_LO} (unsigned 64-bit) sets PEND on the next edge.
REQ-023 AUTO_RELOAD = 1: on the cycle match is detected, MTIME loads 0 instead of incrementing.
REQ-024 intrrupt = PEND & EN, registered; asserts 1 cycle after PEND sets.
REQ-025 PEND clears on STATUS write with wdata[0] = 1 and mask[0] = 1, or on any write to CMP_LO/CMP_HI.
REQ-026 Simultaneous set and clear of PEND in same cycle: set wins.
REQ-027 Simultaneous bus write to MTIME_LO/HI and tick: bus write wins, no increment that cycle.
REQ-028 Read of MTIME_LO latches MTIME[63:32] into a shadow; read of MTIME_HI returns shadow, giving atomic 64-bit read as LO-then-HI.
REQ-029 Read of CMP_LO/CMP_HI/CTRL/STATUS returns live register value.

Reset
REQ-030 reset = 0: MTIME = 0, shadow = 0, CMP = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, PEND = 0, prescaler = 0.
REQ-031 reset = 0: rdata = 0, rvalid = 0, intrrupt = 0 on the same edge.
REQ-032 Reset asserted mid-access: access discarded, no rvalid on the following cycle.

Structure
REQ-033 Shared package timer_irq_pkg holds register offset constants, CTRL/STATUS bit-position constants and the reset value of CMP.
REQ-034 One sub-module timer_prescaler (EN, PRESCALE, clear -> tick) is instantiated; register decode, MTIME, compare and bus logic stay in timer_irq_unit.

Verification
REQ-035 Reset, read CMP_LO at BASE+0x08 -> rvalid 1 cycle later, rdata = 32'hFFFF_FFFF; intrrupt = 0.
REQ-036 CMP = 10, CTRL = 0x1 (PRESCALE 0) -> MTIME reaches 10 after 10 ticks, PEND set next edge, intrrupt high 1 cycle later.
REQ-037 PRESCALE = 3, EN = 1 -> MTIME increments once every 4 cycles; EN = 0 freezes MTIME value.
REQ-038 MTIME = 64'h0000_0000_FFFF_FFFF, EN = 1, PRESCALE 0; read LO then HI across the carry -> HI returns 0 (shadow), next LO/HI pair shows 1.
REQ-039 Pending interrupt, STATUS write 0x1 mask 4'b0001 on a cycle where match still holds -> PEND stays 1 (set wins); after CMP write, PEND = 0 and intrrupt drops 1 cycle later.
REQ-040 AUTO_RELOAD = 1, CMP = 5 -> MTIME sequence 0..5,0,1..., PEND set each wrap until cleared.

Source files
------------

// File: rtl/timer_irq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : timer_irq_pkg                                         |
// | Desc     : Register offsets, CTRL/STATUS bit positions, CMP reset |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package timer_irq_pkg;

  localparam logic [4:0] c_OFF_MTIME_LO = 5'h00;
  localparam logic [4:0] c_OFF_MTIME_HI = 5'h04;
  localparam logic [4:0] c_OFF_CMP_LO   = 5'h08;
  localparam logic [4:0] c_OFF_CMP_HI   = 5'h0C;
  localparam logic [4:0] c_OFF_CTRL     = 5'h10;
  localparam logic [4:0] c_OFF_STATUS   = 5'h14;

  localparam int c_CTRL_EN_BIT     = 0;
  localparam int c_CTRL_AR_BIT     = 1;
  localparam int c_CTRL_PS_LSB     = 8;
  localparam int c_STATUS_PEND_BIT = 0;

  localparam logic [63:0] c_CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_irq_unit_prescaler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : timer_prescaler                                       |
// | Desc     : Divides clk by PRESCALE+1 while enabled, emits a tick  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  clr_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/timer_irq_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : timer_irq_unit                                        |
// | Desc     : 64-bit MTIME timer with compare interrupt, bus regs    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module timer_irq_unit
  import timer_irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mask,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        intrrupt
);

  logic [63:0]           mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0]           shadow_q, shadow_d, rdata_q, rdata_d;
  logic                  en_q, en_d, ar_q, ar_d, pend_q, pend_d;
  logic                  rvalid_q, rvalid_d, intr_q;
  logic [PRESCALE_W-1:0] ps_q, ps_d;

  logic        w_hit, w_wr, w_rd, w_tick, w_match, w_ps_clr;
  logic        w_ctrl_wr, w_cmp_wr, w_status_clr, w_unused;
  logic [4:0]  w_off;
  logic [31:0] w_ctrl, w_ctrl_new;

  assign w_hit = cs && (addr[31:5] == BASE_ADDR[31:5]);
  assign w_wr  = w_hit && wr;
  assign w_rd  = w_hit && !wr;
  assign w_off = {addr[4:2], 2'b00};

  always_comb begin
    w_ctrl = '0;
    w_ctrl[c_CTRL_EN_BIT] = en_q;
    w_ctrl[c_CTRL_AR_BIT] = ar_q;
    w_ctrl[c_CTRL_PS_LSB +: PRESCALE_W] = ps_q;
  end

  assign w_ctrl_new   = byte_merge(w_ctrl, wdata, mask);
  assign w_ctrl_wr    = w_wr && (w_off == c_OFF_CTRL);
  assign w_cmp_wr     = w_wr && ((w_off == c_OFF_CMP_LO) || (w_off == c_OFF_CMP_HI));
  assign w_status_clr = w_wr && (w_off == c_OFF_STATUS) && wdata[c_STATUS_PEND_BIT] && mask[0];

  assign en_d     = w_ctrl_wr ? w_ctrl_new[c_CTRL_EN_BIT] : en_q;
  assign ar_d     = w_ctrl_wr ? w_ctrl_new[c_CTRL_AR_BIT] : ar_q;
  assign ps_d     = w_ctrl_wr ? w_ctrl_new[c_CTRL_PS_LSB +: PRESCALE_W] : ps_q;
  assign w_ps_clr = w_ctrl_wr && !en_q && en_d;

  assign w_unused = ^{addr[1:0], w_ctrl_new[31:c_CTRL_PS_LSB+PRESCALE_W],
                      w_ctrl_new[c_CTRL_PS_LSB-1:c_CTRL_AR_BIT+1]};

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_q),
    .prescale_i (ps_q),
    .clr_i      (w_ps_clr),
    .tick_o     (w_tick)
  );

  always_comb begin
    cmp_d = cmp_q;
    if (w_wr && (w_off == c_OFF_CMP_LO)) cmp_d[31:0]  = byte_merge(cmp_q[31:0], wdata, mask);
    if (w_wr && (w_off == c_OFF_CMP_HI)) cmp_d[63:32] = byte_merge(cmp_q[63:32], wdata, mask);
  end

  // Match uses the compare value that holds after this cycle's write, so
  // reprogramming CMP away from MTIME cannot re-set PEND from the stale value.
  assign w_match = en_q && (mtime_q >= cmp_d);
  assign pend_d  = w_match || (pend_q && !(w_status_clr || w_cmp_wr));

  always_comb begin
    mtime_d = mtime_q;
    if (w_wr && (w_off == c_OFF_MTIME_LO))      mtime_d[31:0]  = byte_merge(mtime_q[31:0], wdata, mask);
    else if (w_wr && (w_off == c_OFF_MTIME_HI)) mtime_d[63:32] = byte_merge(mtime_q[63:32], wdata, mask);
    else if (w_match && ar_q)                   mtime_d = '0;
    else if (w_tick)                            mtime_d = mtime_q + 64'd1;
  end

  always_comb begin
    rdata_d  = '0;
    shadow_d = shadow_q;
    if (w_rd) begin
      case (w_off)
        c_OFF_MTIME_LO: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        c_OFF_MTIME_HI: rdata_d = shadow_q;
        c_OFF_CMP_LO:   rdata_d = cmp_q[31:0];
        c_OFF_CMP_HI:   rdata_d = cmp_q[63:32];
        c_OFF_CTRL:     rdata_d = w_ctrl;
        c_OFF_STATUS:   rdata_d[c_STATUS_PEND_BIT] = pend_q;
        default:        rdata_d = '0;
      endcase
    end
  end
  assign rvalid_d = w_rd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q  <= '0;
      cmp_q    <= c_CMP_RST;
      shadow_q <= '0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      ps_q     <= '0;
      pend_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      ps_q     <= ps_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      intr_q   <= pend_q && en_q;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign intrrupt = intr_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_timer_irq_unit                                     |
// | Desc     : Vector table, directed corner cases, random vs model   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_timer_irq_unit;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        cs    = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask  = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        intrrupt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .mask     (mask),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .intrrupt (intrrupt)
  );

  typedef struct {
    logic        c;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[$];

  // Reference model: architectural state, advanced once per clock edge.
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow, m_rdata;
  logic [7:0]  m_ps;
  logic        m_en, m_ar, m_pend, m_irq, m_rvalid;
  int unsigned m_run;

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic        hit, is_wr, is_rd, tick, match, clr, cmp_wr, mt_wr;
    logic [2:0]  idx;
    logic [31:0] ctrl_rd, ctrl_w, rd;
    logic [63:0] cmp_new, mt_new;
    if (!reset) begin
      m_mtime = '0; m_shadow = '0; m_cmp = '1; m_en = 0; m_ar = 0; m_ps = '0;
      m_run = 0; m_pend = 0; m_irq = 0; m_rdata = '0; m_rvalid = 0;
      return;
    end
    hit   = cs && (addr[31:5] == BASE[31:5]);
    idx   = addr[4:2];
    is_wr = hit && wr;
    is_rd = hit && !wr;
    ctrl_rd = {16'd0, m_ps, 6'd0, m_ar, m_en};
    case (idx)
      3'd0: rd = m_mtime[31:0];
      3'd1: rd = m_shadow;
      3'd2: rd = m_cmp[31:0];
      3'd3: rd = m_cmp[63:32];
      3'd4: rd = ctrl_rd;
      3'd5: rd = {31'd0, m_pend};
      default: rd = '0;
    endcase
    // A tick falls on every (PRESCALE+1)-th enabled cycle since enabling.
    tick = m_en && ((m_run % (m_ps + 1)) == m_ps);
    cmp_new = m_cmp; mt_new = m_mtime; mt_wr = 0; cmp_wr = 0; clr = 0;
    if (is_wr) begin
      case (idx)
        3'd0: begin mt_new[31:0]   = merge32(m_mtime[31:0], wdata, mask);  mt_wr = 1; end
        3'd1: begin mt_new[63:32]  = merge32(m_mtime[63:32], wdata, mask); mt_wr = 1; end
        3'd2: begin cmp_new[31:0]  = merge32(m_cmp[31:0], wdata, mask);    cmp_wr = 1; end
        3'd3: begin cmp_new[63:32] = merge32(m_cmp[63:32], wdata, mask);   cmp_wr = 1; end
        3'd5: clr = wdata[0] && mask[0];
        default: ;
      endcase
    end
    match  = m_en && (m_mtime >= cmp_new);
    m_irq  = m_pend && m_en;
    m_pend = match || (m_pend && !clr && !cmp_wr);
    if (!mt_wr) begin
      if (match && m_ar) mt_new = '0;
      else if (tick)     mt_new = m_mtime + 64'd1;
    end
    if (m_en) m_run++;
    if (is_wr && idx == 3'd4) begin
      ctrl_w = merge32(ctrl_rd, wdata, mask);
      if (!m_en && ctrl_w[0]) m_run = 0;
      m_en = ctrl_w[0]; m_ar = ctrl_w[1]; m_ps = ctrl_w[15:8];
    end
    m_rvalid = is_rd;
    m_rdata  = is_rd ? rd : 32'd0;
    if (is_rd && idx == 3'd0) m_shadow = m_mtime[63:32];
    m_mtime = mt_new;
    m_cmp   = cmp_new;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model rvalid", rvalid, m_rvalid);
    check("model intrrupt", intrrupt, m_irq);
    if (m_rvalid) check("model rdata", rdata, m_rdata);
  endtask

  task automatic bus(input logic w, input logic [4:0] off, input logic [31:0] d, input logic [3:0] m);
    cs = 1'b1; wr = w; addr = BASE + {27'd0, off}; wdata = d; mask = m;
    cycle();
    cs = 1'b0; wr = 1'b0; mask = '0;
  endtask

  task automatic wr32(input logic [4:0] off, input logic [31:0] d);
    bus(1'b1, off, d, 4'hF);
  endtask

  task automatic expect_rd(input string name, input logic [4:0] off, input logic [31:0] exp);
    bus(1'b0, off, 32'd0, 4'h0);
    check({name, " rvalid"}, rvalid, 1'b1);
    check(name, rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  function automatic void add(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic rv, input logic [31:0] rdv);
    vec_t v;
    v.c = c; v.w = w; v.a = a; v.d = d; v.m = m; v.exp_rv = rv; v.exp_rd = rdv;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [4:0]  off;
    logic [31:0] d;
    logic [3:0]  m;

    add(1, 0, BASE + 32'h08, 32'h0,         4'h0, 1, 32'hFFFF_FFFF);
    add(1, 0, BASE + 32'h0C, 32'h0,         4'h0, 1, 32'hFFFF_FFFF);
    add(1, 0, BASE + 32'h00, 32'h0,         4'h0, 1, 32'h0);
    add(1, 0, BASE + 32'h04, 32'h0,         4'h0, 1, 32'h0);
    add(1, 0, BASE + 32'h10, 32'h0,         4'h0, 1, 32'h0);
    add(1, 0, BASE + 32'h14, 32'h0,         4'h0, 1, 32'h0);
    add(1, 0, BASE + 32'h18, 32'h0,         4'h0, 1, 32'h0);
    add(1, 0, BASE + 32'h1C, 32'h0,         4'h0, 1, 32'h0);
    add(0, 0, BASE + 32'h08, 32'h0,         4'h0, 0, 32'h0);
    add(1, 1, BASE + 32'h10, 32'hFFFF_0302, 4'hF, 0, 32'h0);
    add(1, 0, BASE + 32'h10, 32'h0,         4'h0, 1, 32'h0000_0302);
    add(1, 1, BASE + 32'h10, 32'h0000_0500, 4'b0010, 0, 32'h0);
    add(1, 0, BASE + 32'h10, 32'h0,         4'h0, 1, 32'h0000_0502);
    add(1, 1, BASE + 32'h08, 32'h1234_5678, 4'b0101, 0, 32'h0);
    add(1, 0, BASE + 32'h08, 32'h0,         4'h0, 1, 32'hFF34_FF78);
    add(1, 1, BASE + 32'h30, 32'h0000_0001, 4'hF, 0, 32'h0);
    add(1, 0, BASE + 32'h10, 32'h0,         4'h0, 1, 32'h0000_0502);
    add(1, 0, BASE + 32'h28, 32'h0,         4'h0, 0, 32'h0);
    add(1, 1, BASE + 32'h00, 32'hAABB_CCDD, 4'hF, 0, 32'h0);
    add(1, 1, BASE + 32'h04, 32'h1122_3344, 4'b1100, 0, 32'h0);
    add(1, 0, BASE + 32'h00, 32'h0,         4'h0, 1, 32'hAABB_CCDD);
    add(1, 0, BASE + 32'h04, 32'h0,         4'h0, 1, 32'h1122_0000);
    add(1, 1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);
    add(1, 0, BASE + 32'h14, 32'h0,         4'h0, 1, 32'h0);

    idle(3);
    check("reset rvalid", rvalid, 1'b0);
    check("reset intrrupt", intrrupt, 1'b0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      cs = tbl[i].c; wr = tbl[i].w; addr = tbl[i].a; wdata = tbl[i].d; mask = tbl[i].m;
      cycle();
      cs = 1'b0; wr = 1'b0; mask = '0;
      check($sformatf("vec%0d rvalid", i), rvalid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) check($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
    end
    check("irq idle after table", intrrupt, 1'b0);

    // Access coinciding with reset is dropped.
    cs = 1'b1; wr = 1'b0; addr = BASE + 32'h08; reset = 1'b0;
    cycle();
    check("reset-access no rvalid", rvalid, 1'b0);
    cs = 1'b0; reset = 1'b1;
    cycle();
    check("reset-access no late rvalid", rvalid, 1'b0);

    // Compare at 10 with PRESCALE 0, then set-wins and CMP-write clear.
    do_reset();
    wr32(5'h0C, 32'd0);
    wr32(5'h08, 32'd10);
    wr32(5'h10, 32'h1);
    idle(10);
    check("irq before match", intrrupt, 1'b0);
    expect_rd("mtime at 10", 5'h00, 32'd10);
    check("irq on pend edge", intrrupt, 1'b0);
    cycle();
    check("irq after pend", intrrupt, 1'b1);
    expect_rd("status pend", 5'h14, 32'd1);
    bus(1'b1, 5'h14, 32'h1, 4'b0001);
    expect_rd("pend set wins", 5'h14, 32'd1);
    check("irq held", intrrupt, 1'b1);
    wr32(5'h08, 32'hFFFF_FFFF);
    check("irq at cmp write", intrrupt, 1'b1);
    expect_rd("pend after cmp write", 5'h14, 32'd0);
    check("irq dropped", intrrupt, 1'b0);

    // PRESCALE 3: one increment per 4 cycles, freeze on EN=0, restart clears counter.
    do_reset();
    wr32(5'h10, 32'h0301);
    idle(12);
    expect_rd("presc 3 ticks", 5'h00, 32'd3);
    idle(2);
    expect_rd("presc before 4th", 5'h00, 32'd3);
    expect_rd("presc 4th", 5'h00, 32'd4);
    wr32(5'h10, 32'h0300);
    idle(20);
    expect_rd("frozen", 5'h00, 32'd4);
    wr32(5'h10, 32'h0301);
    idle(3);
    expect_rd("reenable no early tick", 5'h00, 32'd4);
    expect_rd("reenable tick", 5'h00, 32'd5);

    // Atomic LO-then-HI read across a 32-bit carry.
    do_reset();
    wr32(5'h00, 32'hFFFF_FFFF);
    wr32(5'h04, 32'h0);
    wr32(5'h10, 32'h1);
    expect_rd("lo before carry", 5'h00, 32'hFFFF_FFFF);
    expect_rd("hi from shadow", 5'h04, 32'h0);
    expect_rd("lo after carry", 5'h00, 32'h1);
    expect_rd("hi after carry", 5'h04, 32'h1);

    // Auto-reload at CMP = 5.
    do_reset();
    wr32(5'h0C, 32'd0);
    wr32(5'h08, 32'd5);
    wr32(5'h10, 32'h3);
    for (int k = 1; k <= 14; k++) begin
      bus(1'b0, 5'h00, 32'd0, 4'h0);
      check($sformatf("reload seq %0d", k), rdata, 32'((k - 1) % 6));
    end
    bus(1'b1, 5'h14, 32'h1, 4'b0001);
    expect_rd("pend cleared", 5'h14, 32'd0);
    idle(2);
    expect_rd("pend on rewrap", 5'h14, 32'd1);

    // Random traffic checked cycle-by-cycle against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = (r < 2) ? 1'b0 : 1'b1;
      off   = {3'($urandom_range(0, 7)), 2'b00};
      d     = $urandom;
      m     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      wr    = 1'($urandom_range(0, 1));
      case (off)
        5'h00: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 80));
        5'h04: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        5'h08: d = 32'($urandom_range(0, 80));
        5'h0C: d = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
        5'h10: begin
          m = 4'hF;
          if ($urandom_range(0, 1) == 1)
            d = {16'd0, 8'($urandom_range(0, 3)), 6'd0, 1'($urandom_range(0, 1)), 1'b0};
          else
            d = {16'd0, m_ps, 6'd0, m_ar, 1'b1};
        end
        default: ;
      endcase
      cs    = (r >= 35) ? 1'b1 : 1'b0;
      addr  = BASE + {27'd0, off} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = addr ^ (32'h1 << $urandom_range(5, 31));
      wdata = d;
      mask  = m;
      cycle();
    end
    cs = 1'b0; wr = 1'b0; reset = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
